wb_stage: RTL and testbench
===========================

# wb_stage

Writeback stage of the single-issue CPU, directly upstream of the register file. Accepts one completed instruction per cycle from the memory stage over a valid/ready handshake. Selects the result source, aligns and extends load data, and drives the register file write port (regwr/rw/busw). Also exports bypass/hazard information to decode and maintains the 64-bit retired-instruction counter.

## Interface
- XLEN, 32, datapath width (only 32 supported)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  memory stage presents an instruction
- in_ready  out  1  stage can accept; equals !rst && state != WAIT_LOAD
- in_rd  in  5  destination register
- in_wen  in  1  instruction writes rd
- in_sel  in  2  result source: 0 ALU, 1 LOAD, 2 PC4, 3 CSR
- in_alu  in  32  ALU result
- in_pc  in  32  instruction PC (PC4 source = in_pc + 4, modulo 2^32)
- in_csr  in  32  CSR read value
- in_funct3  in  3  load width/sign code
- in_addr_lo  in  2  load byte address bits [1:0]
- ld_valid  in  1  load response valid
- ld_data  in  32  aligned 32-bit memory word
- regwr  out  1  register file write enable, one-cycle pulse
- rw  out  5  write register index
- busw  out  32  write data
- ld_pending  out  1  load accepted, awaiting response
- ld_pending_rd  out  5  rd of the pending load
- retire  out  1  one-cycle pulse per completed instruction
- instret  out  64  retired-instruction count

## Operation
- FSM states: IDLE, WAIT_LOAD.
- IDLE, accept with in_sel != LOAD: at the accept edge, register busw = selected source, rw = in_rd, regwr = in_wen && (in_rd != 0), retire = 1. State stays IDLE.
- IDLE, accept with in_sel == LOAD: latch rd, wen, funct3 and addr_lo. Go to WAIT_LOAD. ld_pending = 1 and ld_pending_rd = rd from the next cycle.
- WAIT_LOAD: in_ready = 0. At the edge with ld_valid = 1: busw = extracted data, rw = rd, regwr = wen && rd != 0, retire = 1, state -> IDLE.
- ld_valid is ignored in IDLE.
- Load extraction (funct3):
  - 000 LB: byte addr_lo, sign-extended.
  - 100 LBU: byte addr_lo, zero-extended.
  - 001 LH: half addr_lo[1], sign-extended.
  - 101 LHU: half addr_lo[1], zero-extended.
  - 010 and all other codes: full word.
  - addr_lo[0] is ignored for halfwords.
- rd = 0 or wen = 0: no write, but the instruction still retires and counts.
- regwr and retire fall to 0 in any cycle without a completion. rw and busw hold their last values.
- instret increments by 1 on each completion and wraps from 2^64-1 to 0.

## Timing
- Reset values: regwr 0, rw 0, busw 0, retire 0, instret 0, ld_pending 0, ld_pending_rd 0, state IDLE.
- Non-load latency: 1 cycle, accept edge to regwr high. Throughput is 1 per cycle, back-to-back.
- Load latency: ld_valid edge to regwr high is 1 cycle. The earliest ld_valid is the cycle after acceptance.
- in_ready returns high in the cycle after the response edge. Load-to-next-accept is therefore at least 2 cycles.
- Bypass: regwr/rw/busw are registered and double as the bypass source for decode in the same cycle.
- Reset mid-WAIT_LOAD: the pending load is dropped with no write and no retire. A late ld_valid after reset is ignored.

## Structure
- Shared defines file (wb_defs.vh): WB_SEL_ALU/LOAD/PC4/CSR codes and the funct3 load codes F3_LB/LH/LW/LBU/LHU. The file is shared with decode and the memory stage.
- Sub-module load_align: combinational (ld_data, funct3, addr_lo) -> 32-bit result. Instantiated once.

## Test plan
- ALU back-to-back: rd=5 alu=0x1234, then rd=6 alu=0xFFFF0000 on consecutive cycles -> regwr on two consecutive cycles with rw 5/6 and matching busw, instret=2.
- LB sign: ld_data=0x80FF7F01, addr_lo=3, funct3=000, ld_valid 3 cycles after accept -> busw=0xFFFFFF80, in_ready low for 3 cycles, ld_pending_rd=rd.
- LHU/LH: ld_data=0x8001_7FFE, addr_lo=2 -> LHU busw=0x00008001, LH busw=0xFFFF8001.
- x0 and PC4: rd=0 ALU op -> regwr=0, retire=1, instret increments. Then PC4 with in_pc=0xFFFFFFFC -> busw=0x00000000.
- Reset during WAIT_LOAD: rst one cycle, then ld_valid=1 -> no regwr, no retire, instret=0, in_ready=1 after reset.
- Counter wrap: after forcing instret to 2^64-1, one completion -> instret=0.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared codes for the writeback stage: result-source selects, load funct3
// codes and the FSM state type.
package wb_stage_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_LOAD = 2'd1;
    localparam logic [1:0] WB_SEL_PC4  = 2'd2;
    localparam logic [1:0] WB_SEL_CSR  = 2'd3;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } wb_state_e;

    // Link address for jal/jalr; wraps modulo 2^32.
    function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/wb_stage_load_align.sv
// Load data extraction: picks byte/halfword/word out of the aligned memory
// word and sign- or zero-extends it. Purely combinational.
module load_align
    import wb_stage_pkg::*;
(
    input  logic [31:0] ld_data,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select then extension; addr_lo[0] is a don't-care for halfwords.
    always_comb begin
        byte_sel = ld_data[7:0];
        half_sel = addr_lo[1] ? ld_data[31:16] : ld_data[15:0];
        result   = ld_data;
        case (addr_lo)
            2'd0: byte_sel = ld_data[7:0];
            2'd1: byte_sel = ld_data[15:8];
            2'd2: byte_sel = ld_data[23:16];
            2'd3: byte_sel = ld_data[31:24];
            default: byte_sel = ld_data[7:0];
        endcase
        case (funct3)
            F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  result = {24'd0, byte_sel};
            F3_LH:   result = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  result = {16'd0, half_sel};
            default: result = ld_data;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: accepts completed instructions from the memory stage,
// waits for load responses, drives the register file write port (which also
// serves as the decode bypass source) and counts retired instructions.
//
// state     | meaning
// IDLE      | ready to accept; non-loads complete at the accept edge
// WAIT_LOAD | load accepted, holding rd/wen/funct3/addr_lo until ld_valid
module wb_stage
    import wb_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_rd,
    input  logic        in_wen,
    input  logic [1:0]  in_sel,
    input  logic [31:0] in_alu,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_csr,
    input  logic [2:0]  in_funct3,
    input  logic [1:0]  in_addr_lo,
    input  logic        ld_valid,
    input  logic [31:0] ld_data,
    output logic        regwr,
    output logic [4:0]  rw,
    output logic [31:0] busw,
    output logic        ld_pending,
    output logic [4:0]  ld_pending_rd,
    output logic        retire,
    output logic [63:0] instret
);

    wb_state_e   state_q, state_d;
    logic [4:0]  lat_rd;
    logic        lat_wen;
    logic [2:0]  lat_f3;
    logic [1:0]  lat_lo;
    logic [63:0] instret_q;

    logic        accept;
    logic        latch_load;
    logic        done;
    logic [4:0]  done_rd;
    logic        done_wen;
    logic [31:0] done_data;
    logic [31:0] src_data;
    logic [31:0] ld_result;

    assign in_ready      = !rst && (state_q != WAIT_LOAD);
    assign accept        = in_valid && in_ready;
    assign ld_pending    = (state_q == WAIT_LOAD);
    assign ld_pending_rd = lat_rd;
    assign instret       = instret_q;

    load_align u_load_align (
        .ld_data (ld_data),
        .funct3  (lat_f3),
        .addr_lo (lat_lo),
        .result  (ld_result)
    );

    // Non-load result source mux.
    always_comb begin
        src_data = in_alu;
        case (in_sel)
            WB_SEL_PC4: src_data = pc_plus4(in_pc);
            WB_SEL_CSR: src_data = in_csr;
            default:    src_data = in_alu;
        endcase
    end

    // Next state and completion selection.
    always_comb begin
        state_d    = state_q;
        latch_load = 1'b0;
        done       = 1'b0;
        done_rd    = in_rd;
        done_wen   = in_wen;
        done_data  = src_data;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (in_sel == WB_SEL_LOAD) begin
                        latch_load = 1'b1;
                        state_d    = WAIT_LOAD;
                    end else begin
                        done = 1'b1;
                    end
                end
            end
            WAIT_LOAD: begin
                if (ld_valid) begin
                    done      = 1'b1;
                    done_rd   = lat_rd;
                    done_wen  = lat_wen;
                    done_data = ld_result;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Pending load context.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_rd  <= 5'd0;
            lat_wen <= 1'b0;
            lat_f3  <= 3'd0;
            lat_lo  <= 2'd0;
        end else if (latch_load) begin
            lat_rd  <= in_rd;
            lat_wen <= in_wen;
            lat_f3  <= in_funct3;
            lat_lo  <= in_addr_lo;
        end
    end

    // Register-file write port, retire pulse and instret; rw/busw hold between completions.
    always_ff @(posedge clk) begin
        if (rst) begin
            regwr     <= 1'b0;
            rw        <= 5'd0;
            busw      <= 32'd0;
            retire    <= 1'b0;
            instret_q <= 64'd0;
        end else begin
            regwr  <= done && done_wen && (done_rd != 5'd0);
            retire <= done;
            if (done) begin
                rw        <= done_rd;
                busw      <= done_data;
                instret_q <= instret_q + 64'd1;
            end
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Randomized self-checking bench for wb_stage with a transaction-level model.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic        in_wen;
    logic [1:0]  in_sel;
    logic [31:0] in_alu;
    logic [31:0] in_pc;
    logic [31:0] in_csr;
    logic [2:0]  in_funct3;
    logic [1:0]  in_addr_lo;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        regwr;
    logic [4:0]  rw;
    logic [31:0] busw;
    logic        ld_pending;
    logic [4:0]  ld_pending_rd;
    logic        retire;
    logic [63:0] instret;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] m_instret;
    logic [4:0]  m_rw;
    logic [31:0] m_busw;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_rd         (in_rd),
        .in_wen        (in_wen),
        .in_sel        (in_sel),
        .in_alu        (in_alu),
        .in_pc         (in_pc),
        .in_csr        (in_csr),
        .in_funct3     (in_funct3),
        .in_addr_lo    (in_addr_lo),
        .ld_valid      (ld_valid),
        .ld_data       (ld_data),
        .regwr         (regwr),
        .rw            (rw),
        .busw          (busw),
        .ld_pending    (ld_pending),
        .ld_pending_rd (ld_pending_rd),
        .retire        (retire),
        .instret       (instret)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference load extraction from the ISA definition of each width.
    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] lo,
                                           input logic [31:0] data);
        int unsigned b, h;
        b = (data >> (8 * lo)) & 32'hFF;
        h = (data >> (16 * (lo / 2))) & 32'hFFFF;
        case (f3)
            3'b000: return (b >= 128) ? b - 256 : b;
            3'b100: return b;
            3'b001: return (h >= 32768) ? h - 65536 : h;
            3'b101: return h;
            default: return data;
        endcase
    endfunction

    task automatic drive_idle();
        in_valid   = 1'b0;
        in_rd      = $urandom_range(0, 31);
        in_wen     = $urandom_range(0, 1);
        in_sel     = $urandom_range(0, 3);
        in_alu     = $urandom;
        in_pc      = $urandom;
        in_csr     = $urandom;
        in_funct3  = $urandom_range(0, 7);
        in_addr_lo = $urandom_range(0, 3);
        ld_valid   = 1'b0;
        ld_data    = $urandom;
    endtask

    task automatic check_port(input logic exp_wr, input logic exp_ret);
        check("regwr", regwr, exp_wr);
        check("retire", retire, exp_ret);
        check("rw", rw, m_rw);
        check("busw", busw, m_busw);
        check("instret", instret, m_instret);
    endtask

    task automatic op_idle();
        drive_idle();
        tick();
        check_port(1'b0, 1'b0);
        check("idle_ready", in_ready, 1'b1);
    endtask

    task automatic op_nonload(input logic [4:0] rd, input logic wen, input logic [1:0] sel,
                              input logic [31:0] alu, input logic [31:0] pc,
                              input logic [31:0] csr, input logic ldv);
        check("ready_before", in_ready, 1'b1);
        in_valid   = 1'b1;
        in_rd      = rd;
        in_wen     = wen;
        in_sel     = sel;
        in_alu     = alu;
        in_pc      = pc;
        in_csr     = csr;
        in_funct3  = $urandom_range(0, 7);
        in_addr_lo = $urandom_range(0, 3);
        ld_valid   = ldv;
        ld_data    = $urandom;
        tick();
        m_rw = rd;
        case (sel)
            2'd2:    m_busw = pc + 32'd4;
            2'd3:    m_busw = csr;
            default: m_busw = alu;
        endcase
        m_instret = m_instret + 64'd1;
        check_port(wen && (rd != 0), 1'b1);
        check("pend_after_alu", ld_pending, 1'b0);
    endtask

    task automatic op_load(input logic [4:0] rd, input logic wen, input logic [2:0] f3,
                           input logic [1:0] lo, input logic [31:0] data, input int delay);
        check("ready_before_ld", in_ready, 1'b1);
        in_valid   = 1'b1;
        in_rd      = rd;
        in_wen     = wen;
        in_sel     = 2'd1;
        in_funct3  = f3;
        in_addr_lo = lo;
        ld_valid   = $urandom_range(0, 1);
        tick();
        check_port(1'b0, 1'b0);
        check("ld_pending", ld_pending, 1'b1);
        check("ld_pending_rd", ld_pending_rd, rd);
        check("ready_wait", in_ready, 1'b0);
        for (int i = 1; i < delay; i++) begin
            drive_idle();
            in_valid = $urandom_range(0, 1);
            tick();
            check_port(1'b0, 1'b0);
            check("ready_wait", in_ready, 1'b0);
            check("ld_pending_rd", ld_pending_rd, rd);
        end
        drive_idle();
        in_valid = $urandom_range(0, 1);
        ld_valid = 1'b1;
        ld_data  = data;
        tick();
        m_rw      = rd;
        m_busw    = m_load(f3, lo, data);
        m_instret = m_instret + 64'd1;
        check_port(wen && (rd != 0), 1'b1);
        check("ready_after_ld", in_ready, 1'b1);
        check("pend_after_ld", ld_pending, 1'b0);
        drive_idle();
    endtask

    initial begin
        m_instret = 64'd0;
        m_rw      = 5'd0;
        m_busw    = 32'd0;
        drive_idle();
        rst = 1'b1;
        repeat (2) tick();
        check_port(1'b0, 1'b0);
        check("rst_pending", ld_pending, 1'b0);
        check("rst_pending_rd", ld_pending_rd, 5'd0);
        check("rst_ready", in_ready, 1'b0);
        rst = 1'b0;
        #1;
        check("ready_out_of_rst", in_ready, 1'b1);

        // ALU back-to-back.
        op_nonload(5'd5, 1'b1, 2'd0, 32'h1234, 32'h0, 32'h0, 1'b0);
        op_nonload(5'd6, 1'b1, 2'd0, 32'hFFFF0000, 32'h0, 32'h0, 1'b0);
        check("instret_two", instret, 64'd2);
        op_idle();

        // Load extraction cases.
        op_load(5'd9, 1'b1, 3'b000, 2'd3, 32'h80FF7F01, 3);
        check("lb_sign", busw, 32'hFFFFFF80);
        op_load(5'd10, 1'b1, 3'b101, 2'd2, 32'h80017FFE, 1);
        check("lhu", busw, 32'h00008001);
        op_load(5'd11, 1'b1, 3'b001, 2'd3, 32'h80017FFE, 2);
        check("lh", busw, 32'hFFFF8001);

        // x0 write suppressed but retired; PC4 wraps.
        op_nonload(5'd0, 1'b1, 2'd0, 32'hDEAD, 32'h0, 32'h0, 1'b1);
        op_nonload(5'd7, 1'b1, 2'd2, 32'h0, 32'hFFFFFFFC, 32'h0, 1'b0);
        check("pc4_wrap", busw, 32'h0);
        op_idle();

        // Random mix.
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 4))
                0, 1, 2: op_nonload($urandom_range(0, 31), $urandom_range(0, 1),
                                    ($urandom_range(0, 2) == 0) ? 2'd0 :
                                    (($urandom_range(0, 1) == 0) ? 2'd2 : 2'd3),
                                    $urandom, $urandom, $urandom, $urandom_range(0, 1));
                3: op_load($urandom_range(0, 31), $urandom_range(0, 1), $urandom_range(0, 7),
                           $urandom_range(0, 3), $urandom, $urandom_range(1, 4));
                default: op_idle();
            endcase
        end

        // Reset while a load is pending.
        op_load(5'd12, 1'b1, 3'b010, 2'd0, 32'h0, 1);
        check("ready_before_rl", in_ready, 1'b1);
        in_valid   = 1'b1;
        in_rd      = 5'd13;
        in_wen     = 1'b1;
        in_sel     = 2'd1;
        in_funct3  = 3'b010;
        tick();
        check("rl_pending", ld_pending, 1'b1);
        drive_idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_instret = 64'd0;
        m_rw      = 5'd0;
        m_busw    = 32'd0;
        ld_valid  = 1'b1;
        ld_data   = 32'hCAFEBABE;
        #1;
        check("ready_after_rst", in_ready, 1'b1);
        tick();
        check_port(1'b0, 1'b0);
        check("rl_pending_cleared", ld_pending, 1'b0);
        drive_idle();
        op_idle();

        // instret wrap.
        force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        release dut.instret_q;
        m_instret = 64'hFFFF_FFFF_FFFF_FFFF;
        op_nonload(5'd3, 1'b1, 2'd3, 32'h0, 32'h0, 32'h5A5A5A5A, 1'b0);
        check("instret_wrap", instret, 64'd0);
        op_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
